// File: rtl/pwm_pkg.sv
// Shared types and constants for the multi-channel PWM generator.
// Optional feature macro: PWM_CENTER_EN (center-aligned counting).
package pwm_pkg;

    // Alignment mode latched into the active bank at each period boundary
    typedef enum logic {
        PWM_EDGE   = 1'b0,
        PWM_CENTER = 1'b1
    } pwm_mode_e;

    // Direction of the shared counter in center-aligned mode
    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } pwm_dir_e;

    // Widest counter supported; the active period resets to all ones
    localparam int unsigned PWM_MAX_R = 32;
    localparam logic [PWM_MAX_R-1:0] PERIOD_ACT_RST = '1;

endpackage

// File: rtl/pwm_multi_if.sv
// Control/status bundle between register logic and the PWM generator.
// The master side drives the requests, the slave side is the PWM block.
interface pwm_multi_if #(
    parameter int R = 8,
    parameter int N = 4
) ();

    logic           en;
    logic           center;
    logic [R-1:0]   period;
    logic [N*R-1:0] duty;
    logic           load;
    logic           busy;
    logic           cycle_start;
    logic [N-1:0]   pwm;

    modport master (
        output en, center, period, duty, load,
        input  busy, cycle_start, pwm
    );

    modport slave (
        input  en, center, period, duty, load,
        output busy, cycle_start, pwm
    );

endinterface

// File: rtl/pwm_multi_timer.sv
// Prescaler: asserts done for one clk every final_value cycles while
// enabled (held high when final_value is 1). Clears when disabled.
module pwm_multi_timer #(
    parameter int final_value = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic done
);

    localparam int CW = (final_value > 1) ? $clog2(final_value) : 1;
    localparam logic [CW-1:0] LAST = CW'(final_value - 1);

    logic [CW-1:0] count;

    // Free-running divide counter, restarted whenever the block is disabled
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (!enable) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign done = enable && (count == LAST);

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM generator: one shared prescaled counter, per-channel
// double-buffered duty registers, glitch-free updates at period boundaries.
// Optional feature macro: PWM_CENTER_EN (center-aligned up/down counting).
module pwm_multi
    import pwm_pkg::*;
#(
    parameter int R           = 8,
    parameter int N           = 4,
    parameter int final_value = 20
) (
    input  logic       clk,
    input  logic       reset,
    pwm_multi_if.slave bus
);

    logic tick;

    pwm_multi_timer #(
        .final_value(final_value)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .enable(bus.en),
        .done  (tick)
    );

    // Shared counter and its next value
    logic [R-1:0] cnt;
    logic [R-1:0] cnt_nxt;
    logic         boundary;
    logic         apply;

    // Active and shadow register banks
    logic [R-1:0] period_act;
    logic [R-1:0] period_sh;
    logic [R-1:0] duty_act [N];
    logic [R-1:0] duty_sh  [N];
    logic         busy_q;

    // Registered outputs (one tick behind the count they were computed from)
    logic [N-1:0] cmp;
    logic [N-1:0] pwm_p1;
    logic         cs_p1;

`ifdef PWM_CENTER_EN
    pwm_mode_e center_act;
    pwm_mode_e center_sh;
    pwm_dir_e  dir;
    pwm_dir_e  dir_nxt;
`else
    logic unused_center;
    assign unused_center = bus.center;
`endif

    // Next count and boundary detection; boundary means the count returns to 0
    always_comb begin
        cnt_nxt  = cnt + 1'b1;
        boundary = 1'b0;
`ifdef PWM_CENTER_EN
        dir_nxt  = dir;
        if (center_act == PWM_CENTER) begin
            if (dir == DIR_UP) begin
                if (cnt >= period_act) begin
                    if (period_act <= R'(1)) begin
                        // Degenerate periods: the down leg is empty
                        cnt_nxt  = '0;
                        boundary = 1'b1;
                    end else begin
                        cnt_nxt = cnt - 1'b1;
                        dir_nxt = DIR_DOWN;
                    end
                end
            end else begin
                cnt_nxt = cnt - 1'b1;
                if (cnt <= R'(1)) begin
                    cnt_nxt  = '0;
                    dir_nxt  = DIR_UP;
                    boundary = 1'b1;
                end
            end
        end else begin
            if (cnt >= period_act) begin
                cnt_nxt  = '0;
                dir_nxt  = DIR_UP;
                boundary = 1'b1;
            end
        end
`else
        if (cnt >= period_act) begin
            cnt_nxt  = '0;
            boundary = 1'b1;
        end
`endif
    end

    assign apply = tick && boundary;

    // Per-channel comparators against the pre-increment count
    for (genvar i = 0; i < N; i++) begin : g_cmp
        assign cmp[i] = (cnt < duty_act[i]);
    end

    // Counter, direction and output registers; advance only on prescaler ticks
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt    <= '0;
            pwm_p1 <= '0;
            cs_p1  <= 1'b0;
`ifdef PWM_CENTER_EN
            dir    <= DIR_UP;
`endif
        end else if (!bus.en) begin
            cnt    <= '0;
            pwm_p1 <= '0;
            cs_p1  <= 1'b0;
`ifdef PWM_CENTER_EN
            dir    <= DIR_UP;
`endif
        end else begin
            cs_p1 <= apply;
            if (tick) begin
                cnt    <= cnt_nxt;
                pwm_p1 <= cmp;
`ifdef PWM_CENTER_EN
                dir    <= dir_nxt;
`endif
            end
        end
    end

    // Shadow capture and boundary transfer; a load on the boundary goes straight to active
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q     <= 1'b0;
            period_act <= PERIOD_ACT_RST[R-1:0];
            period_sh  <= '0;
            for (int i = 0; i < N; i++) begin
                duty_act[i] <= '0;
                duty_sh[i]  <= '0;
            end
`ifdef PWM_CENTER_EN
            center_act <= PWM_EDGE;
            center_sh  <= PWM_EDGE;
`endif
        end else if (bus.en) begin
            if (apply) begin
                if (bus.load) begin
                    period_act <= bus.period;
                    for (int i = 0; i < N; i++) begin
                        duty_act[i] <= bus.duty[i*R +: R];
                    end
`ifdef PWM_CENTER_EN
                    center_act <= pwm_mode_e'(bus.center);
`endif
                end else if (busy_q) begin
                    period_act <= period_sh;
                    for (int i = 0; i < N; i++) begin
                        duty_act[i] <= duty_sh[i];
                    end
`ifdef PWM_CENTER_EN
                    center_act <= center_sh;
`endif
                end
                busy_q <= 1'b0;
            end else if (bus.load) begin
                period_sh <= bus.period;
                for (int i = 0; i < N; i++) begin
                    duty_sh[i] <= bus.duty[i*R +: R];
                end
`ifdef PWM_CENTER_EN
                center_sh <= pwm_mode_e'(bus.center);
`endif
                busy_q <= 1'b1;
            end
        end
    end

    assign bus.busy        = busy_q;
    assign bus.cycle_start = cs_p1;
    assign bus.pwm         = pwm_p1;

endmodule
